// File: rtl/ir_regfile_shift_pkg.sv
// Shared types and field positions for the RV64 IR / regfile / shifter slice.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
package ir_rf_pkg;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int IW    = 32;
  localparam int AW    = $clog2(NREGS);
  localparam int OPC_W = 7;

  localparam int RS1_LSB   = 15;
  localparam int RS2_LSB   = 20;
  localparam int RD_LSB    = 7;
  localparam int SHAMT_LSB = 20;
  localparam int SHAMT_W   = 6;

  typedef enum logic [1:0] {
    SH_SLL  = 2'b00,
    SH_SRL  = 2'b01,
    SH_SRA  = 2'b10,
    SH_PASS = 2'b11
  } shift_op_e;

endpackage

// File: rtl/ir_regfile_shift_if.sv
// Control/data bundle between the control unit and the datapath front-end.
// master = control unit side, slave = ir_regfile_shift.
interface ir_regfile_shift_if;
  import ir_rf_pkg::*;

  logic                Load_ir;
  logic [IW-1:0]       Entrada;
  logic                RegWrite;
  logic [XLEN-1:0]     WriteData;
  shift_op_e           Shift;

  logic [IW-1:0]       Instr31_0;
  logic [AW-1:0]       Instr19_15;
  logic [AW-1:0]       Instr24_20;
  logic [AW-1:0]       Instr11_7;
  logic [OPC_W-1:0]    Instr6_0;
  logic [XLEN-1:0]     ReadData1;
  logic [XLEN-1:0]     ReadData2;
  logic [XLEN-1:0]     Saida;

  modport master (
    output Load_ir, Entrada, RegWrite, WriteData, Shift,
    input  Instr31_0, Instr19_15, Instr24_20, Instr11_7,
    input  Instr6_0, ReadData1, ReadData2, Saida
  );

  modport slave (
    input  Load_ir, Entrada, RegWrite, WriteData, Shift,
    output Instr31_0, Instr19_15, Instr24_20, Instr11_7,
    output Instr6_0, ReadData1, ReadData2, Saida
  );

endinterface

// File: rtl/ir_regfile_shift_rf_core.sv
// 32x64 register file: two async read ports, one sync write port, x0 tied to 0.
// REGFILE_BYPASS_EN adds write-through forwarding to both read ports.
module rf_core
  import ir_rf_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] stored1;
  logic [XLEN-1:0] stored2;
  logic            wr_ok;

  assign wr_ok = we && (waddr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  // x0 is decoded on the read side so its storage is never observed
  always_comb begin
    stored1 = '0;
    stored2 = '0;
    if (raddr1 != '0) stored1 = regs[raddr1];
    if (raddr2 != '0) stored2 = regs[raddr2];
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rdata1 = stored1;
    rdata2 = stored2;
    if (wr_ok && (waddr == raddr1)) rdata1 = wdata;
    if (wr_ok && (waddr == raddr2)) rdata2 = wdata;
  end
`else
  assign rdata1 = stored1;
  assign rdata2 = stored2;
`endif

endmodule

// File: rtl/ir_regfile_shift.sv
// Multicycle RV64 front-end: IR, register file and barrel shifter on rs1.
// Define REGFILE_BYPASS_EN for write-through forwarding on the read ports.
module ir_regfile_shift
  import ir_rf_pkg::*;
(
  input  logic           Clk,
  input  logic           Reset,
  ir_regfile_shift_if.slave bus
);

  logic [IW-1:0]      ir;
  logic [AW-1:0]      rs1;
  logic [AW-1:0]      rs2;
  logic [AW-1:0]      rd;
  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    rd1;
  logic [XLEN-1:0]    rd2;
  logic [XLEN-1:0]    saida;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ir <= '0;
    end else if (bus.Load_ir) begin
      ir <= bus.Entrada;
    end
  end

  assign rs1   = ir[RS1_LSB +: AW];
  assign rs2   = ir[RS2_LSB +: AW];
  assign rd    = ir[RD_LSB +: AW];
  assign shamt = ir[SHAMT_LSB +: SHAMT_W];

  // rd comes from the pre-edge IR, so a write alongside Load_ir hits the old rd
  rf_core u_rf (
    .clk    (Clk),
    .rst    (Reset),
    .we     (bus.RegWrite),
    .waddr  (rd),
    .wdata  (bus.WriteData),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rd1),
    .rdata2 (rd2)
  );

  always_comb begin
    saida = rd1;
    unique case (bus.Shift)
      SH_SLL:  saida = rd1 << shamt;
      SH_SRL:  saida = rd1 >> shamt;
      SH_SRA:  saida = $signed(rd1) >>> shamt;
      SH_PASS: saida = rd1;
    endcase
  end

  assign bus.Instr31_0  = ir;
  assign bus.Instr19_15 = rs1;
  assign bus.Instr24_20 = rs2;
  assign bus.Instr11_7  = rd;
  assign bus.Instr6_0   = ir[OPC_W-1:0];
  assign bus.ReadData1  = rd1;
  assign bus.ReadData2  = rd2;
  assign bus.Saida      = saida;

endmodule

// File: tb/tb_ir_regfile_shift.sv
// Self-checking bench for ir_regfile_shift: shifter vector table plus
// hand sequences for reset, IR decode, x0, read-during-write and hold.
module tb_ir_regfile_shift;
  import ir_rf_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [63:0] sb [$];

  ir_regfile_shift_if bus();

  ir_regfile_shift dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] data;
    logic [5:0]  shamt;
    logic [5:0]  hi;
    shift_op_e   op;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_ir(input logic [31:0] w);
    bus.Load_ir = 1'b1;
    bus.Entrada = w;
    tick();
    bus.Load_ir = 1'b0;
  endtask

  task automatic write_rd(input logic [63:0] d);
    bus.RegWrite  = 1'b1;
    bus.WriteData = d;
    tick();
    bus.RegWrite  = 1'b0;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] hi,
                                     input logic [5:0] sh,
                                     input logic [4:0] r1,
                                     input logic [4:0] rdd);
    return {hi, sh, r1, 3'b000, rdd, 7'h13};
  endfunction

  logic [31:0] held;

  initial begin
    vecs[0]  = '{"sll4",   64'h8000_0000_0000_00F0, 6'd4,  6'd0,  SH_SLL,  64'h0000_0000_0000_0F00};
    vecs[1]  = '{"srl4",   64'h8000_0000_0000_00F0, 6'd4,  6'd0,  SH_SRL,  64'h0800_0000_0000_000F};
    vecs[2]  = '{"sra4",   64'h8000_0000_0000_00F0, 6'd4,  6'd0,  SH_SRA,  64'hF800_0000_0000_000F};
    vecs[3]  = '{"pass4",  64'h8000_0000_0000_00F0, 6'd4,  6'd0,  SH_PASS, 64'h8000_0000_0000_00F0};
    vecs[4]  = '{"sra63",  64'h8000_0000_0000_00F0, 6'd63, 6'd0,  SH_SRA,  64'hFFFF_FFFF_FFFF_FFFF};
    vecs[5]  = '{"srl63",  64'h8000_0000_0000_00F0, 6'd63, 6'd0,  SH_SRL,  64'h0000_0000_0000_0001};
    vecs[6]  = '{"sll63z", 64'h8000_0000_0000_00F0, 6'd63, 6'd0,  SH_SLL,  64'h0000_0000_0000_0000};
    vecs[7]  = '{"sll63",  64'h0000_0000_0000_0001, 6'd63, 6'd0,  SH_SLL,  64'h8000_0000_0000_0000};
    vecs[8]  = '{"sra0",   64'h1234_5678_9ABC_DEF0, 6'd0,  6'd0,  SH_SRA,  64'h1234_5678_9ABC_DEF0};
    vecs[9]  = '{"sra1pos",64'h7000_0000_0000_0000, 6'd1,  6'd0,  SH_SRA,  64'h3800_0000_0000_0000};
    vecs[10] = '{"hi_ign", 64'h0000_0000_0000_00F0, 6'd4,  6'h3F, SH_SLL,  64'h0000_0000_0000_0F00};
    vecs[11] = '{"srl32",  64'hFFFF_FFFF_FFFF_FFFF, 6'd32, 6'd0,  SH_SRL,  64'h0000_0000_FFFF_FFFF};

    bus.Load_ir   = 1'b0;
    bus.Entrada   = '0;
    bus.RegWrite  = 1'b0;
    bus.WriteData = '0;
    bus.Shift     = SH_PASS;

    tick();
    tick();
    check("rst_ir", 64'(bus.Instr31_0), 64'h0);
    check("rst_rd1", bus.ReadData1, 64'h0);
    check("rst_saida", bus.Saida, 64'h0);
    rst = 1'b0;
    tick();

    // IR decode and first write
    load_ir(32'h00A2_82B3);
    check("rs1", 64'(bus.Instr19_15), 64'd5);
    check("rs2", 64'(bus.Instr24_20), 64'd10);
    check("rd", 64'(bus.Instr11_7), 64'd5);
    check("opc", 64'(bus.Instr6_0), 64'h33);
    write_rd(64'hDEAD_BEEF);
    check("wr_x5", bus.ReadData1, 64'hDEAD_BEEF);
    check("x10_0", bus.ReadData2, 64'h0);

    // Asynchronous reset mid-cycle
    write_rd(64'h1234);
    check("x5_1234", bus.ReadData1, 64'h1234);
    #2 rst = 1'b1;
    #1;
    check("arst_ir", 64'(bus.Instr31_0), 64'h0);
    check("arst_rd1", bus.ReadData1, 64'h0);
    tick();
    rst = 1'b0;
    load_ir(32'h00A2_82B3);
    check("arst_x5", bus.ReadData1, 64'h0);

    // x0 discards writes and is never forwarded
    load_ir(32'h0000_0033);
    bus.RegWrite  = 1'b1;
    bus.WriteData = 64'hFFFF_FFFF_FFFF_FFFF;
    #2;
    check("x0_pre", bus.ReadData1, 64'h0);
    tick();
    bus.RegWrite = 1'b0;
    check("x0_rd1", bus.ReadData1, 64'h0);
    check("x0_rd2", bus.ReadData2, 64'h0);

    // Read-during-write on x3
    load_ir(32'h0001_81B3);
    write_rd(64'd7);
    check("x3_7", bus.ReadData1, 64'd7);
    bus.RegWrite  = 1'b1;
    bus.WriteData = 64'd9;
    #2;
`ifdef REGFILE_BYPASS_EN
    check("rdw_pre", bus.ReadData1, 64'd9);
`else
    check("rdw_pre", bus.ReadData1, 64'd7);
`endif
    tick();
    bus.RegWrite = 1'b0;
    check("rdw_post", bus.ReadData1, 64'd9);

    // Load_ir with RegWrite: write goes to old rd (x3)
    bus.Load_ir   = 1'b1;
    bus.Entrada   = mk(6'd0, 6'd0, 5'd3, 5'd4);
    bus.RegWrite  = 1'b1;
    bus.WriteData = 64'h55;
    tick();
    bus.Load_ir  = 1'b0;
    bus.RegWrite = 1'b0;
    check("li_rw_x3", bus.ReadData1, 64'h55);
    check("li_rw_rd", 64'(bus.Instr11_7), 64'd4);
    load_ir(mk(6'd0, 6'd0, 5'd4, 5'd4));
    check("li_rw_x4", bus.ReadData1, 64'h0);
    load_ir(mk(6'd0, 6'd0, 5'd3, 5'd3));

    // Hold behaviour
    held = bus.Instr31_0;
    for (int i = 0; i < 4; i++) begin
      bus.Entrada   = $urandom();
      bus.WriteData = {$urandom(), $urandom()};
      tick();
    end
    check("hold_ir", 64'(bus.Instr31_0), 64'(held));
    check("hold_x3", bus.ReadData1, 64'h55);

    // Shifter table, scoreboard queue pairs drive and sample
    for (int i = 0; i < 12; i++) begin
      load_ir(mk(vecs[i].hi, vecs[i].shamt, 5'd1, 5'd1));
      write_rd(vecs[i].data);
      bus.Shift = vecs[i].op;
      sb.push_back(vecs[i].exp);
      #2;
      check({vecs[i].name, "_x1"}, bus.ReadData1, vecs[i].data);
      check(vecs[i].name, bus.Saida, sb.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
